// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants and types for the load/store unit: RISC-V
//               funct3 width codes, byte-enable width and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane steering. Stores are shifted into
//               their lanes across a two-word window (phase selects the low or
//               high word); loads are extracted from the {hi, lo} word pair
//               and sign/zero extended. A single-word access only uses phase 0
//               and the low word, so the same logic covers split accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic            phase,
    input  logic [31:0]     store_data,
    input  logic [31:0]     lo_word,
    input  logic [31:0]     hi_word,
    output logic [BE_W-1:0] be,
    output logic [31:0]     lane_wdata,
    output logic [31:0]     load_data
);

    logic [3:0]  w_size_mask;
    logic [31:0] w_store_masked;
    logic [7:0]  w_be_wide;
    logic [63:0] w_wd_wide;
    logic [31:0] w_rd_low;

    // Lane steering for stores and extraction/extension for loads.
    always_comb begin
        w_size_mask    = 4'b0001;
        w_store_masked = {24'd0, store_data[7:0]};
        case (funct3[1:0])
            2'b01: begin
                w_size_mask    = 4'b0011;
                w_store_masked = {16'd0, store_data[15:0]};
            end
            2'b10: begin
                w_size_mask    = 4'b1111;
                w_store_masked = store_data;
            end
            default: ;
        endcase

        w_be_wide  = {4'b0000, w_size_mask} << offset;
        w_wd_wide  = {32'd0, w_store_masked} << {offset, 3'b000};
        w_rd_low   = 32'({hi_word, lo_word} >> {offset, 3'b000});

        be         = phase ? w_be_wide[7:4] : w_be_wide[3:0];
        lane_wdata = phase ? w_wd_wide[63:32] : w_wd_wide[31:0];

        case (funct3)
            F3_B:    load_data = {{24{w_rd_low[7]}}, w_rd_low[7:0]};
            F3_H:    load_data = {{16{w_rd_low[15]}}, w_rd_low[15:0]};
            F3_BU:   load_data = {24'd0, w_rd_low[7:0]};
            F3_HU:   load_data = {16'd0, w_rd_low[15:0]};
            default: load_data = w_rd_low;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts one load/store at a time,
//               issues word-aligned requests with byte enables, waits for
//               grant / read data and returns a one-cycle response pulse.
//               Optional macro LSU_MISALIGN_SPLIT_EN: misaligned accesses are
//               performed (word-crossing ones as two word accesses, low word
//               first) instead of being rejected with resp_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic              phase_q, phase_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;

    logic              w_illegal;
    logic              w_req_err;
    logic              w_split_en;
    logic [BE_W-1:0]   w_be;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_load_data;
    logic [ADDR_W-1:0] w_word_addr;

    // Reserved funct3 codes, and unsigned forms used with a store.
    assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Only word-crossing accesses need the second (phase 1) memory access.
    assign w_req_err  = w_illegal;
    assign w_split_en = ((f3_q[1:0] == 2'b01) && (addr_q[1:0] == 2'b11)) ||
                        ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
    logic w_misalign;
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_req_err  = w_illegal || w_misalign;
    assign w_split_en = 1'b0;
`endif

    // Phase 1 targets the word after the one holding the start byte.
    assign w_word_addr = {addr_q[ADDR_W-1:2], 2'b00} +
                         {{(ADDR_W-3){1'b0}}, phase_q, 2'b00};

    lsu_align u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .phase      (phase_q),
        .store_data (wdata_q),
        .lo_word    (lo_q),
        .hi_word    (hi_q),
        .be         (w_be),
        .lane_wdata (w_lane_wdata),
        .load_data  (w_load_data)
    );

    // State and captured-request registers; reset drops any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            phase_q <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic: accept, issue, wait for read data, respond.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        phase_d = phase_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    phase_d = 1'b0;
                    err_d   = w_req_err;
                    state_d = w_req_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_gnt) begin
                    if (!we_q) begin
                        state_d = ST_WAIT;
                    end else if (w_split_en && !phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (phase_q) begin
                        hi_d    = mem_rdata;
                        state_d = ST_RESP;
                    end else begin
                        lo_d = mem_rdata;
                        if (w_split_en) begin
                            phase_d = 1'b1;
                            state_d = ST_ACCESS;
                        end else begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the state register so reset clears them at once.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_req    = (state_q == ST_ACCESS);
        mem_we     = mem_req && we_q;
        mem_addr   = mem_req ? w_word_addr : '0;
        mem_be     = mem_req ? w_be : '0;
        mem_wdata  = mem_we ? w_lane_wdata : '0;
        resp_valid = (state_q == ST_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !we_q && !err_q) ? w_load_data : '0;
        resp_rd    = (resp_valid && !we_q) ? rd_q : 5'd0;
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomised self-checking bench for load_store_unit. Expected
//               memory transactions and load results are derived byte by byte
//               from the access rules; a memory responder supplies data and
//               optionally withholds grant. Honours LSU_MISALIGN_SPLIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Memory contents: a fixed word for directed tests, else an address hash.
    bit          mem_fixed_en;
    logic [31:0] mem_fixed_val;

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        if (mem_fixed_en) return mem_fixed_val;
        return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } xact_t;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // One request end to end: model expectation, drive, respond, compare.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input int gnt_dly);
        int          size;
        bit          illegal, mis, err;
        xact_t       exp_q[$];
        xact_t       cur, first;
        logic [31:0] ba, wa, mw, raw, exp_data;
        int          lane, lat_exp, cyc, wcnt, nx;
        bit          have_cur, pend, in_acc, done;
        logic [31:0] pend_addr;

        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3[2]);
        mis     = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
        err     = illegal || (mis && !SPLIT);
        raw      = '0;
        have_cur = 0;
        cur      = '0;
        if (!err) begin
            for (int i = 0; i < size; i++) begin
                ba   = addr + i;
                wa   = {ba[31:2], 2'b00};
                lane = int'(ba[1:0]);
                if (!have_cur || cur.addr != wa) begin
                    if (have_cur) exp_q.push_back(cur);
                    cur      = '0;
                    cur.addr = wa;
                    have_cur = 1;
                end
                cur.be[lane]            = 1'b1;
                cur.wdata[lane*8 +: 8]  = wdata[i*8 +: 8];
                mw                      = mem_word(wa);
                raw[i*8 +: 8]           = mw[lane*8 +: 8];
            end
            exp_q.push_back(cur);
        end
        case (f3)
            3'd0:    exp_data = {{24{raw[7]}}, raw[7:0]};
            3'd1:    exp_data = {{16{raw[15]}}, raw[15:0]};
            3'd4:    exp_data = {24'd0, raw[7:0]};
            3'd5:    exp_data = {16'd0, raw[15:0]};
            default: exp_data = raw;
        endcase
        if (err || we) exp_data = '0;
        lat_exp = 1;
        foreach (exp_q[k]) lat_exp += (we ? 1 : 2) + gnt_dly;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;

        cyc = 0; wcnt = 0; nx = 0; pend = 0; in_acc = 0; done = 0;
        first = '0; pend_addr = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (cyc == 1) check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
                pend       = 0;
            end
            if (mem_req) begin
                if (!in_acc) begin
                    in_acc      = 1;
                    wcnt        = 0;
                    first.addr  = mem_addr;
                    first.be    = mem_be;
                    first.wdata = mem_wdata;
                    if (nx < exp_q.size()) begin
                        check("mem_addr", mem_addr, exp_q[nx].addr);
                        check("mem_be", {28'd0, mem_be}, {28'd0, exp_q[nx].be});
                        check("mem_we", {31'd0, mem_we}, {31'd0, we});
                        if (we) check("mem_wdata", mem_wdata & be_mask(exp_q[nx].be),
                                      exp_q[nx].wdata & be_mask(exp_q[nx].be));
                    end else begin
                        check("unexpected_mem_req", 32'd1, 32'd0);
                    end
                end else begin
                    check("hold_addr", mem_addr, first.addr);
                    check("hold_be", {28'd0, mem_be}, {28'd0, first.be});
                    check("hold_wdata", mem_wdata, first.wdata);
                end
                if (wcnt >= gnt_dly) begin
                    mem_gnt = 1'b1;
                    in_acc  = 0;
                    nx++;
                    if (!mem_we) begin
                        pend      = 1;
                        pend_addr = mem_addr;
                    end
                end else begin
                    wcnt++;
                end
            end
            if (resp_valid) begin
                done = 1;
                check("resp_err", {31'd0, resp_err}, {31'd0, err});
                check("resp_rdata", resp_rdata, exp_data);
                check("resp_rd", {27'd0, resp_rd}, we ? 32'd0 : {27'd0, rd});
                check("latency", cyc, lat_exp);
            end
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        check("xact_count", nx, exp_q.size());
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        mem_fixed_en = 1'b0; mem_fixed_val = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        mem_fixed_en = 1'b1; mem_fixed_val = 32'hDEADBEEF;
        run_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd3, 0);      // LW
        mem_fixed_val = 32'h80FF_0000;
        run_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 0);      // LB
        run_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 0);      // LBU
        run_req(1'b1, 3'b001, 32'h22, 32'h0000_1234, 5'd6, 0); // SH
        mem_fixed_en = 1'b0;
        run_req(1'b0, 3'b010, 32'h11, 32'h0, 5'd7, 3);      // misaligned LW, slow grant
        run_req(1'b0, 3'b011, 32'h20, 32'h0, 5'd8, 0);      // illegal funct3
        run_req(1'b1, 3'b100, 32'h20, 32'h55, 5'd9, 0);     // store with U form
        run_req(1'b1, 3'b010, 32'h3F, 32'hCAFEF00D, 5'd1, 1); // crossing SW

        // Reset while waiting for read data.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rstmid_access", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rstmid_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check("late_rvalid_resp", {31'd0, resp_valid}, 32'd0);
        check("late_rvalid_ready", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, 3'b010, 32'h40, 32'h0, 5'd10, 0);

        // Randomised traffic.
        for (int n = 0; n < 80; n++) begin
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 255)), $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
